// File: rtl/sound_mulacc_par_if.sv
// Bus between the channel sequencer (master) and the volume-by-sample
// multiplier-accumulator (slave).
interface sound_mulacc_par_if #(
  parameter int VOL_W = 6,
  parameter int DAT_W = 8,
  parameter int SUM_W = 16
);
  logic [VOL_W-1:0]        vol_in;
  logic [DAT_W-1:0]        dat_in;
  logic                    load;
  logic                    clr_sum;
  logic                    ready;
  logic                    ovf;
  logic signed [SUM_W-1:0] sum_out;

  modport master (
    output vol_in, dat_in, load, clr_sum,
    input  ready, ovf, sum_out
  );

  modport slave (
    input  vol_in, dat_in, load, clr_sum,
    output ready, ovf, sum_out
  );
endinterface

// File: rtl/sound_mulacc_par.sv
// Serial volume-by-sample multiplier-accumulator for the sound mixer.
// The offset-binary sample is turned into two's complement, multiplied by the
// unsigned volume with one shift-add step per sample bit (the MSB step
// subtracts), and the product is added into a signed running sum that either
// saturates or wraps. Any signed overflow sets a sticky flag.
module sound_mulacc_par #(
  parameter int VOL_W    = 6,
  parameter int DAT_W    = 8,
  parameter int SUM_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clock,
  input  logic              rst_n,
  sound_mulacc_par_if.slave bus
);
  localparam int P_W   = VOL_W + DAT_W + 1;
  localparam int CNT_W = (DAT_W > 1) ? $clog2(DAT_W) : 1;
  localparam logic [CNT_W-1:0]        LAST_STEP = CNT_W'(DAT_W - 1);
  localparam logic signed [SUM_W-1:0] SUM_MAX   = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN   = {1'b1, {(SUM_W-1){1'b0}}};

  // The final add is done at SUM_W+1 bits and relies on the product fitting.
  generate
    if (SUM_W < VOL_W + DAT_W) begin : g_width_check
      $error("sound_mulacc_par: SUM_W must be >= VOL_W + DAT_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t                  state_reg, state_next;
  logic [VOL_W-1:0]        vol_reg;
  logic [DAT_W-1:0]        d_reg;
  logic                    clr_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [P_W-1:0]   psum_reg;
  logic signed [SUM_W-1:0] sum_reg;
  logic                    ovf_reg;

  logic signed [P_W-1:0]   vol_shift;
  logic signed [P_W-1:0]   psum_step;
  logic signed [SUM_W:0]   prod_ext;
  logic signed [SUM_W:0]   acc_sum;
  logic                    acc_ovf;
  logic signed [SUM_W-1:0] acc_result;

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: a load in any state (re)starts the multiply at step 0.
  always_comb begin
    state_next = state_reg;
    if (bus.load) begin
      state_next = MUL;
    end else begin
      case (state_reg)
        MUL:     if (cnt_reg == LAST_STEP) state_next = ACC;
        ACC:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // One shift-add step; the sample MSB carries negative weight, so subtract there.
  always_comb begin
    vol_shift = $signed(P_W'(vol_reg) << cnt_reg);
    psum_step = psum_reg;
    if (d_reg[cnt_reg]) begin
      psum_step = (cnt_reg == LAST_STEP) ? psum_reg - vol_shift
                                         : psum_reg + vol_shift;
    end
  end

  // Final accumulate with one guard bit; overflow when the top two bits differ.
  always_comb begin
    prod_ext   = (SUM_W+1)'(psum_reg);
    acc_sum    = clr_reg ? prod_ext : (SUM_W+1)'(sum_reg) + prod_ext;
    acc_ovf    = acc_sum[SUM_W] ^ acc_sum[SUM_W-1];
    acc_result = acc_sum[SUM_W-1:0];
    if (acc_ovf && SATURATE) acc_result = acc_sum[SUM_W] ? SUM_MIN : SUM_MAX;
  end

  // Datapath: latch on load, step in MUL, publish sum/ovf only in ACC.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vol_reg  <= '0;
      d_reg    <= '0;
      clr_reg  <= 1'b0;
      cnt_reg  <= '0;
      psum_reg <= '0;
      sum_reg  <= '0;
      ovf_reg  <= 1'b0;
    end else if (bus.load) begin
      vol_reg  <= bus.vol_in;
      d_reg    <= {~bus.dat_in[DAT_W-1], bus.dat_in[DAT_W-2:0]};
      clr_reg  <= bus.clr_sum;
      cnt_reg  <= '0;
      psum_reg <= '0;
    end else if (state_reg == MUL) begin
      psum_reg <= psum_step;
      cnt_reg  <= cnt_reg + CNT_W'(1);
    end else if (state_reg == ACC) begin
      sum_reg  <= acc_result;
      ovf_reg  <= clr_reg ? acc_ovf : (ovf_reg | acc_ovf);
    end
  end

  assign bus.ready   = (state_reg == IDLE);
  assign bus.ovf     = ovf_reg;
  assign bus.sum_out = sum_reg;
endmodule

// File: tb/tb_sound_mulacc_par.sv
// Bench for sound_mulacc_par: a saturating and a wrapping instance share the
// same stimulus and are compared against an integer reference model.
module tb_sound_mulacc_par;
  logic clock = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model state, one copy per overflow mode.
  int sum_sat  = 0;
  int sum_wrap = 0;
  bit ovf_sat  = 1'b0;
  bit ovf_wrap = 1'b0;

  sound_mulacc_par_if #(.VOL_W(6), .DAT_W(8), .SUM_W(16)) bus_s ();
  sound_mulacc_par_if #(.VOL_W(6), .DAT_W(8), .SUM_W(16)) bus_w ();

  sound_mulacc_par #(.VOL_W(6), .DAT_W(8), .SUM_W(16), .SATURATE(1'b1)) dut_sat (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  sound_mulacc_par #(.VOL_W(6), .DAT_W(8), .SUM_W(16), .SATURATE(1'b0)) dut_wrap (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_w.slave)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] v, input logic [7:0] d, input logic c, input logic ld);
    bus_s.vol_in = v; bus_s.dat_in = d; bus_s.clr_sum = c; bus_s.load = ld;
    bus_w.vol_in = v; bus_w.dat_in = d; bus_w.clr_sum = c; bus_w.load = ld;
  endtask

  // Offset-binary sample: value is the raw code minus 128.
  function automatic void model_op(input int v, input int draw, input bit c);
    int p;
    int s;
    bit o;
    p = (draw - 128) * v;
    s = c ? p : sum_sat + p;
    o = (s > 32767) || (s < -32768);
    sum_sat = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    ovf_sat = c ? o : (ovf_sat | o);
    s = c ? p : sum_wrap + p;
    o = (s > 32767) || (s < -32768);
    while (s > 32767)  s -= 65536;
    while (s < -32768) s += 65536;
    sum_wrap = s;
    ovf_wrap = c ? o : (ovf_wrap | o);
  endfunction

  task automatic check_outputs(input string tag);
    logic [15:0] es;
    logic [15:0] ew;
    es = 16'(sum_sat);
    ew = 16'(sum_wrap);
    check_val({tag, "_sum_sat"},  {16'h0, bus_s.sum_out}, {16'h0, es});
    check_val({tag, "_ovf_sat"},  {31'h0, bus_s.ovf},     {31'h0, ovf_sat});
    check_val({tag, "_sum_wrap"}, {16'h0, bus_w.sum_out}, {16'h0, ew});
    check_val({tag, "_ovf_wrap"}, {31'h0, bus_w.ovf},     {31'h0, ovf_wrap});
  endtask

  // One operation; if abort_k > 0 a second load (v2,d2,c2) lands on edge E_abort_k.
  task automatic run_op(input string tag, input logic [5:0] v, input logic [7:0] d, input logic c,
                        input int abort_k, input logic [5:0] v2, input logic [7:0] d2, input logic c2);
    logic [15:0] old_s;
    logic [15:0] old_w;
    logic        old_os;
    logic        old_ow;
    bit          held;
    int          lat;
    held = 1'b1;
    lat  = 0;
    @(negedge clock);
    old_s = bus_s.sum_out; old_w = bus_w.sum_out; old_os = bus_s.ovf; old_ow = bus_w.ovf;
    drive(v, d, c, 1'b1);
    @(negedge clock);
    drive(v, d, c, 1'b0);
    if (abort_k > 0) begin
      for (int i = 1; i < abort_k; i++) begin
        if (bus_s.ready || bus_w.ready || bus_s.sum_out != old_s || bus_w.sum_out != old_w ||
            bus_s.ovf != old_os || bus_w.ovf != old_ow) held = 1'b0;
        @(negedge clock);
      end
      if (bus_s.ready || bus_w.ready) held = 1'b0;
      drive(v2, d2, c2, 1'b1);
      @(negedge clock);
      drive(v2, d2, c2, 1'b0);
      v = v2; d = d2; c = c2;
    end
    while (!bus_s.ready && lat < 20) begin
      if (bus_s.sum_out != old_s || bus_w.sum_out != old_w ||
          bus_s.ovf != old_os || bus_w.ovf != old_ow) held = 1'b0;
      @(negedge clock);
      lat++;
    end
    model_op(int'(v), int'(d), c);
    check_val({tag, "_latency"}, 32'(lat), 32'd9);
    check_val({tag, "_held"}, {31'h0, held}, 32'd1);
    check_val({tag, "_ready_wrap"}, {31'h0, bus_w.ready}, 32'd1);
    check_outputs(tag);
    $display("op %s vol=%0d dat=0x%02h clr=%0d abort=%0d -> sat=0x%04h ovf=%0d wrap=0x%04h ovf=%0d",
             tag, v, d, c, abort_k, bus_s.sum_out, bus_s.ovf, bus_w.sum_out, bus_w.ovf);
  endtask

  initial begin
    logic [5:0] rv, rv2;
    logic [7:0] rd, rd2;
    logic       rc, rc2;
    int         rk;

    drive(6'd0, 8'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst_ready", {31'h0, bus_s.ready}, 32'd1);
    check_outputs("rst");
    rst_n = 1'b1;

    run_op("pos_full", 6'd63, 8'hFF, 1'b1, 0, 6'd0, 8'h00, 1'b0);
    check_val("pos_full_const", {16'h0, bus_s.sum_out}, 32'h1F41);
    run_op("neg_full", 6'd63, 8'h00, 1'b1, 0, 6'd0, 8'h00, 1'b0);
    check_val("neg_full_const", {16'h0, bus_s.sum_out}, 32'hE080);
    run_op("zero_samp", 6'd1, 8'h80, 1'b0, 0, 6'd0, 8'h00, 1'b0);

    for (int i = 0; i < 5; i++) run_op("acc_pos", 6'd63, 8'hFF, (i == 0), 0, 6'd0, 8'h00, 1'b0);
    check_val("acc_pos_sat_const",  {16'h0, bus_s.sum_out}, 32'h7FFF);
    check_val("acc_pos_wrap_const", {16'h0, bus_w.sum_out}, 32'h9C45);
    for (int i = 0; i < 5; i++) run_op("acc_neg", 6'd63, 8'h00, (i == 0), 0, 6'd0, 8'h00, 1'b0);
    check_val("acc_neg_sat_const", {16'h0, bus_s.sum_out}, 32'h8000);
    run_op("clear", 6'd0, 8'hFF, 1'b1, 0, 6'd0, 8'h00, 1'b0);

    run_op("abort_e4", 6'd63, 8'hFF, 1'b0, 4, 6'd2, 8'h81, 1'b1);
    check_val("abort_e4_const", {16'h0, bus_s.sum_out}, 32'h0002);
    run_op("abort_acc", 6'd40, 8'h10, 1'b0, 9, 6'd5, 8'hF0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rv  = 6'($urandom_range(0, 63));
      rd  = 8'($urandom_range(0, 255));
      rc  = ($urandom_range(0, 3) == 0);
      rv2 = 6'($urandom_range(0, 63));
      rd2 = 8'($urandom_range(0, 255));
      rc2 = ($urandom_range(0, 3) == 0);
      rk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      run_op("rand", rv, rd, rc, rk, rv2, rd2, rc2);
    end

    // Reset in the middle of an operation.
    run_op("pre_rst", 6'd63, 8'hFF, 1'b1, 0, 6'd0, 8'h00, 1'b0);
    @(negedge clock);
    drive(6'd33, 8'hC0, 1'b0, 1'b1);
    @(negedge clock);
    drive(6'd33, 8'hC0, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #1 rst_n = 1'b0;
    #1;
    sum_sat = 0; sum_wrap = 0; ovf_sat = 1'b0; ovf_wrap = 1'b0;
    check_val("midrst_ready", {31'h0, bus_s.ready}, 32'd1);
    check_outputs("midrst");
    $display("op midrst -> ready=%0d sat=0x%04h wrap=0x%04h", bus_s.ready, bus_s.sum_out, bus_w.sum_out);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (12) @(negedge clock);
    check_val("postrst_ready", {31'h0, bus_s.ready}, 32'd1);
    check_outputs("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
